vga_cmd_arbiter: RTL
====================

VGA_CMD_ARBITER -- requirements
Module: vga_cmd_arbiter

Interface
REQ-001 The block SHALL have parameter P_FIFO_DEPTH, default 8, meaning the result FIFO depth in entries (power of 2, at least 2).
REQ-002 The block SHALL have parameter P_ECHO_COLOR, default 8'h0F, meaning the COLOR value for echo commands.
REQ-003 The block SHALL have parameter P_RES_COLOR, default 8'h0A, meaning the COLOR value for result characters and the result newline.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 Ports SHALL be:
- CLK  in  1  -- 50 MHz system clock.
- RST  in  1  -- asynchronous reset, active-high.
- ECHO_VALID  in  1  -- echo command offered.
- ECHO_CMD  in  2  -- 00 display, 01 delete, 10 newline, 11 null.
- ECHO_ASCII  in  8  -- echo character.
- ECHO_READY  out  1  -- echo holding register empty.
- RES_VALID  in  1  -- result character offered.
- RES_ASCII  in  8  -- result character.
- RES_LAST  in  1  -- last character of the result string.
- RES_READY  out  1  -- result FIFO not full.
- VGA_READY  in  1  -- VGA sink accepts the current command.
- OUT_VALID  out  1  -- command presented.
- COMMAND  out  2  -- command code.
- ASCII_OUT  out  8  -- character.
- COLOR  out  8  -- character color.

Function
REQ-006 An echo transfer SHALL occur when ECHO_VALID & ECHO_READY; it loads a one-entry holding register, and ECHO_READY SHALL drop in the next cycle until that entry is issued.
REQ-007 An echo transfer carrying ECHO_CMD=11 SHALL be discarded, SHALL NOT occupy the holding register and SHALL NOT produce output.
REQ-008 A result transfer SHALL occur when RES_VALID & RES_READY; it pushes {RES_LAST, RES_ASCII} into the FIFO.
REQ-009 RES_READY SHALL equal "FIFO not full", and a pop in the same cycle SHALL NOT raise RES_READY combinationally.
REQ-010 The FIFO pointers SHALL wrap modulo P_FIFO_DEPTH, and the FIFO SHALL keep a separate count so that full and empty are never ambiguous.
REQ-011 The output register (OUT_VALID, COMMAND, ASCII_OUT, COLOR) SHALL hold its value stable while OUT_VALID & ~VGA_READY.
REQ-012 The output register SHALL load a new command only when it is empty or being accepted in the current cycle, so that back-to-back issue at one command per cycle is possible.
REQ-013 The FSM SHALL have four states with these actions:
- IDLE -- no burst in progress.
- ECHO -- echo entry issued.
- RES -- result burst in progress.
- NL -- newline pending.
REQ-014 From IDLE, a pending echo entry SHALL be issued first (echo priority), with COMMAND=ECHO_CMD and COLOR=P_ECHO_COLOR; otherwise, if the FIFO is non-empty, the FSM SHALL enter RES and issue the head entry.
REQ-015 In RES, the FSM SHALL issue only FIFO entries (COMMAND=00, COLOR=P_RES_COLOR), locking out echo, until the entry with LAST=1 is accepted, and SHALL then go to NL.
REQ-016 In NL, the FSM SHALL issue COMMAND=10, ASCII_OUT=8'h0D, COLOR=P_RES_COLOR, and on acceptance return to IDLE.
REQ-017 In RES, if the FIFO becomes empty before LAST, the FSM SHALL stay in RES with OUT_VALID=0 and SHALL NOT time out.
REQ-018 Latency SHALL be one cycle: an echo accepted in cycle N with the arbiter idle SHALL appear with OUT_VALID=1 in cycle N+1.
REQ-019 If echo and result arrive in the same cycle while IDLE, echo SHALL be issued first, and the result burst SHALL start on the next free output slot.
REQ-020 ECHO_READY SHALL remain a function only of holding-register occupancy, so that one echo can be buffered during a result burst.

Reset
REQ-021 While RST=1, asynchronously, the block SHALL force:
- FSM to IDLE.
- FIFO empty (pointers and count 0).
- Holding register empty.
- OUT_VALID=0, COMMAND=11, ASCII_OUT=8'h00, COLOR=8'h00.
- ECHO_READY=1 and RES_READY=1 from the first cycle after release.
REQ-022 A reset asserted mid-burst SHALL discard all buffered data, and after release no partial result or pending newline SHALL be emitted.

Structure
REQ-023 The command codes (00/01/10/11), the CR code 8'h0D and the FSM state encodings SHALL be shared constants in the common settings package used by the keyboard datapath.
REQ-024 The result FIFO SHALL be a separate sub-module named res_fifo (parameter P_FIFO_DEPTH, data width 9, push/pop/full/empty/count).
REQ-025 Implementation SHALL be 120-400 lines of RTL.

Verification
REQ-026 Single echo: ECHO_CMD=00, ASCII=8'h41 at cycle 0 with VGA_READY=1 -> OUT_VALID at cycle 1 with COMMAND=00, ASCII_OUT=8'h41, COLOR=8'h0F, then OUT_VALID=0 at cycle 2.
REQ-027 Result burst: push "1","2","3" (LAST on "3") -> output 8'h31, 8'h32, 8'h33 with COMMAND=00 and COLOR=8'h0A, followed by COMMAND=10 with ASCII_OUT=8'h0D; an echo 8'h42 offered mid-burst is emitted only after the newline.
REQ-028 Backpressure: VGA_READY=0 for 5 cycles with a command presented -> outputs stable for all 5 cycles, no loss, and order preserved on release.
REQ-029 FIFO full: push 8 entries with no LAST while VGA_READY=0 -> RES_READY=0 after the 8th push; a 9th push is ignored; draining restores RES_READY=1 and the pointers wrap correctly.
REQ-030 Simultaneous events: echo 8'h08 (ECHO_CMD=01) and result "7"/LAST arrive in the same cycle while IDLE -> the delete command is issued first, then 8'h37, then the newline.
REQ-031 Reset mid-burst: assert RST after 2 of 4 result characters -> outputs go to reset values at once; after release, no further output until new input arrives.

Source files
------------

// File: rtl/vga_cmd_arbiter_pkg.sv
// ============================================================================
// Module : vga_cmd_arbiter_pkg
// Brief  : Shared command codes, CR character and arbiter state encodings.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package vga_cmd_arbiter_pkg;

    localparam logic [1:0] C_CMD_DISPLAY = 2'b00;
    localparam logic [1:0] C_CMD_DELETE  = 2'b01;
    localparam logic [1:0] C_CMD_NEWLINE = 2'b10;
    localparam logic [1:0] C_CMD_NULL    = 2'b11;

    localparam logic [7:0] C_ASCII_CR    = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ECHO = 2'd1,
        ST_RES  = 2'd2,
        ST_NL   = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic       last;
        logic [7:0] ascii;
    } res_entry_t;

endpackage

`default_nettype wire

// File: rtl/vga_cmd_arbiter_res.sv
// ============================================================================
// Module : res_fifo
// Brief  : Result character FIFO with separate occupancy count.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module res_fifo #(
    parameter int P_FIFO_DEPTH = 8,
    parameter int P_WIDTH      = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [P_WIDTH-1:0]            din,
    output logic [P_WIDTH-1:0]            dout,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(P_FIFO_DEPTH):0] count
);

    localparam int                C_PTR_W   = $clog2(P_FIFO_DEPTH);
    localparam logic [C_PTR_W-1:0] C_PTR_ONE = C_PTR_W'(1);
    localparam logic [C_PTR_W:0]   C_CNT_ONE = (C_PTR_W + 1)'(1);
    localparam logic [C_PTR_W:0]   C_CNT_MAX = (C_PTR_W + 1)'(P_FIFO_DEPTH);

    logic [P_WIDTH-1:0] r_mem [P_FIFO_DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_PTR_W:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == C_CNT_MAX);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/vga_cmd_arbiter.sv
// ============================================================================
// Module : vga_cmd_arbiter
// Brief  : Merges keyboard echo commands and result strings into one VGA stream.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vga_cmd_arbiter
    import vga_cmd_arbiter_pkg::*;
#(
    parameter int         P_FIFO_DEPTH = 8,
    parameter logic [7:0] P_ECHO_COLOR = 8'h0F,
    parameter logic [7:0] P_RES_COLOR  = 8'h0A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       echo_valid,
    input  logic [1:0] echo_cmd,
    input  logic [7:0] echo_ascii,
    output logic       echo_ready,
    input  logic       res_valid,
    input  logic [7:0] res_ascii,
    input  logic       res_last,
    output logic       res_ready,
    input  logic       vga_ready,
    output logic       out_valid,
    output logic [1:0] command,
    output logic [7:0] ascii_out,
    output logic [7:0] color
);

    arb_state_t                    r_state;
    logic                          r_hold_valid;
    logic [1:0]                    r_hold_cmd;
    logic [7:0]                    r_hold_ascii;
    logic                          r_last_out;
    logic                          r_out_valid;
    logic [1:0]                    r_command;
    logic [7:0]                    r_ascii;
    logic [7:0]                    r_color;

    res_entry_t                    w_fifo_dout;
    logic                          w_fifo_full;
    logic                          w_fifo_empty;
    logic [$clog2(P_FIFO_DEPTH):0] w_fifo_count;
    logic                          w_unused_count;
    logic                          w_echo_new;
    logic                          w_echo_avail;
    logic [1:0]                    w_echo_cmd;
    logic [7:0]                    w_echo_ascii;
    logic                          w_load;
    logic                          w_free;
    logic                          w_issue_echo;
    logic                          w_issue_res;
    logic                          w_issue_nl;

    res_fifo #(
        .P_FIFO_DEPTH (P_FIFO_DEPTH),
        .P_WIDTH      (9)
    ) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (res_valid),
        .pop   (w_issue_res),
        .din   ({res_last, res_ascii}),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    assign w_unused_count = ^w_fifo_count;

    assign echo_ready = ~r_hold_valid;
    assign res_ready  = ~w_fifo_full;
    assign out_valid  = r_out_valid;
    assign command    = r_command;
    assign ascii_out  = r_ascii;
    assign color      = r_color;

    // A fresh echo bypasses the holding register when it can issue at once.
    assign w_echo_new   = echo_valid & ~r_hold_valid & (echo_cmd != C_CMD_NULL);
    assign w_echo_avail = r_hold_valid | w_echo_new;
    assign w_echo_cmd   = r_hold_valid ? r_hold_cmd   : echo_cmd;
    assign w_echo_ascii = r_hold_valid ? r_hold_ascii : echo_ascii;

    // In NL the output is always valid, so a load there means the newline left.
    assign w_load       = ~r_out_valid | vga_ready;
    assign w_free       = (r_state != ST_RES);
    assign w_issue_echo = w_load & w_free & w_echo_avail;
    assign w_issue_res  = w_load & ~w_fifo_empty &
                          ((w_free & ~w_echo_avail) | ((r_state == ST_RES) & ~r_last_out));
    assign w_issue_nl   = w_load & (r_state == ST_RES) & r_last_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
            r_hold_cmd   <= C_CMD_NULL;
            r_hold_ascii <= 8'h00;
        end else if (w_issue_echo && r_hold_valid) begin
            r_hold_valid <= 1'b0;
        end else if (w_echo_new && !w_issue_echo) begin
            r_hold_valid <= 1'b1;
            r_hold_cmd   <= echo_cmd;
            r_hold_ascii <= echo_ascii;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_last_out  <= 1'b0;
            r_out_valid <= 1'b0;
            r_command   <= C_CMD_NULL;
            r_ascii     <= 8'h00;
            r_color     <= 8'h00;
        end else if (w_issue_echo) begin
            r_state     <= ST_ECHO;
            r_last_out  <= 1'b0;
            r_out_valid <= 1'b1;
            r_command   <= w_echo_cmd;
            r_ascii     <= w_echo_ascii;
            r_color     <= P_ECHO_COLOR;
        end else if (w_issue_res) begin
            r_state     <= ST_RES;
            r_last_out  <= w_fifo_dout.last;
            r_out_valid <= 1'b1;
            r_command   <= C_CMD_DISPLAY;
            r_ascii     <= w_fifo_dout.ascii;
            r_color     <= P_RES_COLOR;
        end else if (w_issue_nl) begin
            r_state     <= ST_NL;
            r_last_out  <= 1'b0;
            r_out_valid <= 1'b1;
            r_command   <= C_CMD_NEWLINE;
            r_ascii     <= C_ASCII_CR;
            r_color     <= P_RES_COLOR;
        end else if (w_load) begin
            // A starved burst keeps RES so echo stays locked out until LAST.
            r_out_valid <= 1'b0;
            if (r_state != ST_RES) r_state <= ST_IDLE;
        end
    end

endmodule

`default_nettype wire
